// File: rtl/jpd_pkg.sv
// rtl/jpd_pkg.sv - shared types and helpers for the Johnson phase decoder
// Purpose: lock FSM state type, phase-width helper and ring-step helper.
// Ports: none (package).
package jpd_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQ      = 2'd1,
    LOCKED   = 2'd2
  } jpd_state_e;

  // Phase index width for a Johnson ring of 2*cnt_size phases.
  function automatic int ph_width(input int cnt_size);
    return $clog2(2 * cnt_size);
  endfunction

  // Successor phase on the ring; 2N-1 wraps to 0.
  function automatic int unsigned next_phase(input int unsigned p, input int unsigned ring_len);
    return (p + 1 == ring_len) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// rtl/johnson_code_decode.sv - combinational Johnson code to phase index decoder
// Purpose: classifies a CNT_SIZE-bit twisted-ring code as legal or not and
//          returns its phase index (MSB-first fill).
// Ports:
//   jc     in   CNT_SIZE  Johnson code
//   legal  out  1         code is one of the 2*CNT_SIZE ring states
//   phase  out  PH_W      phase index (meaningful only when legal)
module johnson_code_decode #(
  parameter int CNT_SIZE = 8,
  parameter int PH_W     = 4
) (
  input  logic [CNT_SIZE-1:0] jc,
  output logic                legal,
  output logic [PH_W-1:0]     phase
);

  logic [PH_W-1:0] ones;
  logic [PH_W-1:0] edges;

  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < CNT_SIZE; i++) begin
      ones = ones + PH_W'(jc[i]);
    end
    // A ring state is one run of 1s and one run of 0s: at most one bit boundary.
    for (int i = 0; i < CNT_SIZE - 1; i++) begin
      edges = edges + PH_W'(jc[i] ^ jc[i+1]);
    end
    legal = (edges <= PH_W'(1));
    // Filling half (MSB set, or all zero) counts its 1s; draining half is 2N - ones.
    if (jc[CNT_SIZE-1] || (ones == '0)) begin
      phase = ones;
    end else begin
      phase = PH_W'(2 * CNT_SIZE) - ones;
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - Johnson count decoder with step check and lock FSM
// Purpose: registers phase index / one-hot strobe of each sampled Johnson code,
//          flags illegal codes and non +1 steps, tracks lock, pulses on revolution.
// Optional feature macro: JPD_ERR_CNT_EN (saturating error counter).
// Ports:
//   clk         in   1           clock
//   rst         in   1           asynchronous active-low reset
//   in_vld      in   1           jc_in is meaningful
//   jc_in       in   CNT_SIZE    Johnson code
//   err_clr     in   1           synchronous clear of err_cnt
//   phase       out  PH_W        decoded phase index
//   phase_vld   out  1           phase/phase_oh valid
//   phase_oh    out  2*CNT_SIZE  one-hot phase strobe
//   locked      out  1           lock FSM in LOCKED
//   cycle_done  out  1           wrap 2N-1 -> 0 while locked
//   code_err    out  1           illegal code pulse
//   step_err    out  1           legal code but not previous phase + 1
//   err_cnt     out  ERR_W       saturating error count
module johnson_phase_decoder
  import jpd_pkg::*;
#(
  parameter int CNT_SIZE = 8,
  parameter int PH_W     = ph_width(CNT_SIZE),
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [CNT_SIZE-1:0]   jc_in,
  input  logic                  err_clr,
  output logic [PH_W-1:0]       phase,
  output logic                  phase_vld,
  output logic [2*CNT_SIZE-1:0] phase_oh,
  output logic                  locked,
  output logic                  cycle_done,
  output logic                  code_err,
  output logic                  step_err,
  output logic [ERR_W-1:0]      err_cnt
);

  localparam int RING = 2 * CNT_SIZE;

  logic            dec_legal;
  logic [PH_W-1:0] dec_phase;
  logic [PH_W-1:0] phase_succ;
  logic            sample_ok;
  logic            sample_bad;
  logic            step_good;
  logic            step_bad;
  logic            armed;
  logic [3:0]      gcnt;
  logic [3:0]      gcnt_inc;
  logic [RING-1:0] oh_d;
  jpd_state_e      state;

  johnson_code_decode #(
    .CNT_SIZE(CNT_SIZE),
    .PH_W    (PH_W)
  ) u_decode (
    .jc   (jc_in),
    .legal(dec_legal),
    .phase(dec_phase)
  );

  assign phase_succ = PH_W'(next_phase(32'(phase), RING));
  assign sample_ok  = in_vld & dec_legal;
  assign sample_bad = in_vld & ~dec_legal;
  // armed means the previous cycle held a legal sample, so phase is a valid reference.
  assign step_good  = sample_ok & armed & (dec_phase == phase_succ);
  assign step_bad   = sample_ok & armed & (dec_phase != phase_succ);
  assign gcnt_inc   = gcnt + 4'd1;
  assign locked     = (state == LOCKED);

  always_comb begin
    oh_d = '0;
    if (sample_ok) begin
      oh_d[dec_phase] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase      <= '0;
      phase_vld  <= 1'b0;
      phase_oh   <= '0;
      cycle_done <= 1'b0;
      code_err   <= 1'b0;
      step_err   <= 1'b0;
      armed      <= 1'b0;
      gcnt       <= '0;
      state      <= UNLOCKED;
    end else begin
      phase_vld  <= sample_ok;
      phase_oh   <= oh_d;
      code_err   <= sample_bad;
      step_err   <= step_bad;
      armed      <= sample_ok;
      // A good step landing on 0 can only have come from 2N-1.
      cycle_done <= (state == LOCKED) & step_good & (dec_phase == '0);
      if (sample_ok) begin
        phase <= dec_phase;
      end
      case (state)
        UNLOCKED: begin
          if (sample_ok) begin
            state <= ACQ;
            gcnt  <= '0;
          end
        end
        ACQ: begin
          if (!sample_ok) begin
            state <= UNLOCKED;
          end else if (step_bad) begin
            gcnt <= '0;
          end else begin
            gcnt <= gcnt_inc;
            if (gcnt_inc == 4'(LOCK_CNT)) begin
              state <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (!sample_ok) begin
            state <= UNLOCKED;
          end else if (step_bad) begin
            // Lock is lost, but the new code is legal, so acquisition reseeds from it at once.
            state <= ACQ;
            gcnt  <= '0;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

`ifdef JPD_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if ((sample_bad | step_bad) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb/tb_johnson_phase_decoder.sv - self-checking bench for johnson_phase_decoder
module tb_johnson_phase_decoder;

  localparam int N        = 8;
  localparam int RING     = 2 * N;
  localparam int LOCK_CNT = 4;
`ifdef JPD_ERR_CNT_EN
  localparam bit ERR_EN   = 1'b1;
`else
  localparam bit ERR_EN   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [7:0]  jc_in;
  logic        err_clr;
  logic [3:0]  phase;
  logic        phase_vld;
  logic [15:0] phase_oh;
  logic        locked;
  logic        cycle_done;
  logic        code_err;
  logic        step_err;
  logic [7:0]  err_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state and expected outputs
  int          m_phase, m_good, m_err;
  bit          m_armed, m_track, m_locked;
  bit          e_vld, e_cd, e_ce, e_se;
  logic [15:0] e_oh;

  johnson_phase_decoder #(
    .CNT_SIZE(N),
    .PH_W    (4),
    .LOCK_CNT(LOCK_CNT),
    .ERR_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .jc_in     (jc_in),
    .err_clr   (err_clr),
    .phase     (phase),
    .phase_vld (phase_vld),
    .phase_oh  (phase_oh),
    .locked    (locked),
    .cycle_done(cycle_done),
    .code_err  (code_err),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Ring code for phase k built straight from the fill rule.
  function automatic logic [7:0] code_of(input int k);
    logic [7:0] c;
    c = '0;
    if (k <= N) begin
      for (int i = 0; i < k; i++) c[N-1-i] = 1'b1;
    end else begin
      for (int i = 0; i < RING - k; i++) c[i] = 1'b1;
    end
    return c;
  endfunction

  function automatic int decode_ref(input logic [7:0] c);
    for (int k = 0; k < RING; k++) begin
      if (code_of(k) == c) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_good = 0; m_err = 0;
    m_armed = 0; m_track = 0; m_locked = 0;
    e_vld = 0; e_cd = 0; e_ce = 0; e_se = 0; e_oh = '0;
  endtask

  task automatic model(input logic v, input logic [7:0] c, input logic clr);
    int d;
    bit legal, correct;
    d       = v ? decode_ref(c) : -1;
    legal   = (d >= 0);
    correct = legal && m_armed && (d == (m_phase + 1) % RING);
    e_ce    = v && !legal;
    e_se    = legal && m_armed && !correct;
    e_cd    = m_locked && correct && (d == 0);
    e_vld   = legal;
    e_oh    = legal ? (16'd1 << d) : 16'd0;
    if (legal) m_phase = d;
    if (!legal) begin
      m_track = 0; m_locked = 0; m_good = 0;
    end else if (!m_track) begin
      m_track = 1; m_good = 0;
    end else if (correct) begin
      m_good++;
      if (m_good >= LOCK_CNT) m_locked = 1;
    end else begin
      m_good = 0; m_locked = 0;
    end
    if (ERR_EN) begin
      if (clr) m_err = 0;
      else if ((e_ce || e_se) && m_err < 255) m_err++;
    end
    m_armed = legal;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic clr);
    in_vld  = v;
    jc_in   = c;
    err_clr = clr;
    model(v, c, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total_cnt++; if (phase !== 4'd0) $display("FAIL reset_phase: got %0d expected 0", phase); else pass_cnt++;
    total_cnt++; if (phase_vld !== 1'b0) $display("FAIL reset_phase_vld: got %b expected 0", phase_vld); else pass_cnt++;
    total_cnt++; if (phase_oh !== 16'd0) $display("FAIL reset_phase_oh: got %h expected 0", phase_oh); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked); else pass_cnt++;
    total_cnt++; if ({cycle_done, code_err, step_err} !== 3'b000) $display("FAIL reset_pulses: got %b expected 000", {cycle_done, code_err, step_err}); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); else pass_cnt++;
  endtask

  task automatic test_acquire();
    logic [7:0] codes [5];
    int         ph    [5];
    codes = '{8'h01, 8'h00, 8'h80, 8'hC0, 8'hE0};
    ph    = '{15, 0, 1, 2, 3};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, codes[i], 1'b0);
      total_cnt++; if (phase !== 4'(ph[i])) $display("FAIL acq_phase[%0d]: got %0d expected %0d", i, phase, ph[i]); else pass_cnt++;
      total_cnt++; if (phase_oh !== (16'd1 << ph[i])) $display("FAIL acq_oh[%0d]: got %h expected %h", i, phase_oh, 16'd1 << ph[i]); else pass_cnt++;
      total_cnt++; if (locked !== (i == 4)) $display("FAIL acq_locked[%0d]: got %b expected %b", i, locked, i == 4); else pass_cnt++;
      total_cnt++; if (cycle_done !== 1'b0) $display("FAIL acq_cycle_done[%0d]: got %b expected 0", i, cycle_done); else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    for (int k = 4; k < RING; k++) drive(1'b1, code_of(k), 1'b0);
    total_cnt++; if (locked !== 1'b1 || cycle_done !== 1'b0 || phase !== 4'd15) $display("FAIL wrap_pre: got locked=%b cd=%b phase=%0d expected 1 0 15", locked, cycle_done, phase); else pass_cnt++;
    drive(1'b1, 8'h00, 1'b0);
    total_cnt++; if (phase !== 4'd0) $display("FAIL wrap_phase: got %0d expected 0", phase); else pass_cnt++;
    total_cnt++; if (cycle_done !== 1'b1) $display("FAIL wrap_cycle_done: got %b expected 1", cycle_done); else pass_cnt++;
    drive(1'b1, 8'h80, 1'b0);
    total_cnt++; if (cycle_done !== 1'b0) $display("FAIL wrap_cycle_done_clear: got %b expected 0", cycle_done); else pass_cnt++;
  endtask

  task automatic test_code_err();
    drive(1'b1, 8'hA0, 1'b0);
    total_cnt++; if (code_err !== 1'b1) $display("FAIL cerr_pulse: got %b expected 1", code_err); else pass_cnt++;
    total_cnt++; if (phase_vld !== 1'b0 || phase_oh !== 16'd0) $display("FAIL cerr_vld: got vld=%b oh=%h expected 0 0", phase_vld, phase_oh); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL cerr_locked: got %b expected 0", locked); else pass_cnt++;
    total_cnt++; if (phase !== 4'd1 || step_err !== 1'b0) $display("FAIL cerr_hold: got phase=%0d serr=%b expected 1 0", phase, step_err); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'(ERR_EN ? 1 : 0)) $display("FAIL cerr_count: got %0d expected %0d", err_cnt, ERR_EN ? 1 : 0); else pass_cnt++;
    drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (code_err !== 1'b0) $display("FAIL cerr_one_cycle: got %b expected 0", code_err); else pass_cnt++;
  endtask

  task automatic test_step_err();
    logic [7:0] codes [5];
    codes = '{8'h03, 8'h01, 8'h00, 8'h80, 8'hC0};
    for (int i = 0; i < 5; i++) drive(1'b1, codes[i], 1'b0);
    total_cnt++; if (locked !== 1'b1 || phase !== 4'd2) $display("FAIL serr_pre: got locked=%b phase=%0d expected 1 2", locked, phase); else pass_cnt++;
    drive(1'b1, 8'hF0, 1'b0);
    total_cnt++; if (step_err !== 1'b1 || code_err !== 1'b0) $display("FAIL serr_pulse: got serr=%b cerr=%b expected 1 0", step_err, code_err); else pass_cnt++;
    total_cnt++; if (phase !== 4'd4 || phase_vld !== 1'b1) $display("FAIL serr_phase: got %0d vld=%b expected 4 1", phase, phase_vld); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL serr_locked: got %b expected 0", locked); else pass_cnt++;
    // Acquisition restarts from phase 4: four good steps relock.
    for (int k = 5; k <= 8; k++) begin
      drive(1'b1, code_of(k), 1'b0);
      total_cnt++; if (locked !== (k == 8) || step_err !== 1'b0) $display("FAIL serr_relock[%0d]: got locked=%b serr=%b expected %b 0", k, locked, step_err, k == 8); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    in_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    test_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_random();
    int         rp, r;
    logic       clr;
    logic [7:0] c;
    rp = int'($urandom_range(RING - 1));
    for (int n = 0; n < 400; n++) begin
      r   = int'($urandom_range(99));
      clr = ($urandom_range(19) == 0);
      if (r < 80) begin
        rp = (rp + 1) % RING;
        drive(1'b1, code_of(rp), clr);
      end else if (r < 88) begin
        rp = int'($urandom_range(RING - 1));
        drive(1'b1, code_of(rp), clr);
      end else if (r < 94) begin
        do c = 8'($urandom); while (decode_ref(c) >= 0);
        drive(1'b1, c, clr);
      end else begin
        drive(1'b0, 8'($urandom), clr);
      end
      total_cnt++; if (phase !== 4'(m_phase)) $display("FAIL rnd_phase@%0d: got %0d expected %0d", n, phase, m_phase); else pass_cnt++;
      total_cnt++; if (phase_vld !== e_vld) $display("FAIL rnd_vld@%0d: got %b expected %b", n, phase_vld, e_vld); else pass_cnt++;
      total_cnt++; if (phase_oh !== e_oh) $display("FAIL rnd_oh@%0d: got %h expected %h", n, phase_oh, e_oh); else pass_cnt++;
      total_cnt++; if (locked !== m_locked) $display("FAIL rnd_locked@%0d: got %b expected %b", n, locked, m_locked); else pass_cnt++;
      total_cnt++; if (cycle_done !== e_cd) $display("FAIL rnd_cycle_done@%0d: got %b expected %b", n, cycle_done, e_cd); else pass_cnt++;
      total_cnt++; if (code_err !== e_ce) $display("FAIL rnd_code_err@%0d: got %b expected %b", n, code_err, e_ce); else pass_cnt++;
      total_cnt++; if (step_err !== e_se) $display("FAIL rnd_step_err@%0d: got %b expected %b", n, step_err, e_se); else pass_cnt++;
      total_cnt++; if (err_cnt !== 8'(m_err)) $display("FAIL rnd_err_cnt@%0d: got %0d expected %0d", n, err_cnt, m_err); else pass_cnt++;
    end
  endtask

  task automatic test_err_sat();
    repeat (300) drive(1'b1, 8'hA5, 1'b0);
    total_cnt++; if (err_cnt !== 8'(ERR_EN ? 255 : 0)) $display("FAIL sat_err_cnt: got %0d expected %0d", err_cnt, ERR_EN ? 255 : 0); else pass_cnt++;
    drive(1'b1, 8'hA5, 1'b1);
    total_cnt++; if (err_cnt !== 8'd0) $display("FAIL sat_clr_priority: got %0d expected 0", err_cnt); else pass_cnt++;
    total_cnt++; if (code_err !== 1'b1) $display("FAIL sat_code_err: got %b expected 1", code_err); else pass_cnt++;
    drive(1'b1, 8'hA5, 1'b0);
    total_cnt++; if (err_cnt !== 8'(ERR_EN ? 1 : 0)) $display("FAIL sat_restart: got %0d expected %0d", err_cnt, ERR_EN ? 1 : 0); else pass_cnt++;
  endtask

  initial begin
    rst     = 1'b0;
    in_vld  = 1'b0;
    jc_in   = '0;
    err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    test_acquire();
    test_wrap();
    test_code_err();
    test_step_err();
    test_async_reset();
    test_random();
    test_err_sat();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
